// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: key codes, controller states
// and the entry-progress codes exported to the display path.
package calc_pkg;

   localparam logic [7:0] KEY_DIG_MAX = 8'h09;
   localparam logic [7:0] OP_ADD      = 8'hF0;
   localparam logic [7:0] OP_SUB      = 8'hF1;
   localparam logic [7:0] OP_MUL      = 8'hF2;
   localparam logic [7:0] OP_DIV      = 8'hF3;
   localparam logic [7:0] KEY_EQU     = 8'hE0;
   localparam logic [7:0] KEY_CLR     = 8'hE1;

   localparam int unsigned WD_W = 4;

   typedef enum logic [8:0] {
      ST_IDLE   = 9'b0_0000_0001,
      ST_A1     = 9'b0_0000_0010,
      ST_A0     = 9'b0_0000_0100,
      ST_OP     = 9'b0_0000_1000,
      ST_B1     = 9'b0_0001_0000,
      ST_B0     = 9'b0_0010_0000,
      ST_CALC   = 9'b0_0100_0000,
      ST_RESULT = 9'b0_1000_0000,
      ST_ERR    = 9'b1_0000_0000
   } state_e;

   localparam logic [2:0] STG_IDLE   = 3'd0;
   localparam logic [2:0] STG_A1     = 3'd1;
   localparam logic [2:0] STG_A0     = 3'd2;
   localparam logic [2:0] STG_OPB1   = 3'd3;
   localparam logic [2:0] STG_B0     = 3'd4;
   localparam logic [2:0] STG_RESULT = 3'd5;
   localparam logic [2:0] STG_ERROR  = 3'd6;

   // CALC keeps the "entry complete" code so the display does not flicker
   // while the datapath works.
   function automatic logic [2:0] stage_of(state_e s);
      logic [2:0] stg;
      stg = STG_IDLE;
      case (s)
         ST_A1:          stg = STG_A1;
         ST_A0:          stg = STG_A0;
         ST_OP, ST_B1:   stg = STG_OPB1;
         ST_B0, ST_CALC: stg = STG_B0;
         ST_RESULT:      stg = STG_RESULT;
         ST_ERR:         stg = STG_ERROR;
         default:        stg = STG_IDLE;
      endcase
      return stg;
   endfunction

endpackage

// File: rtl/calc_key_classify.sv
// Combinational key decoder shared by the sequencing controller and the
// display path.
module calc_key_classify
   import calc_pkg::*;
(
   input  logic [7:0] key_code,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_equ,
   output logic       is_clr
);

   assign is_digit = (key_code <= KEY_DIG_MAX);
   assign is_op    = (key_code >= OP_ADD) && (key_code <= OP_DIV);
   assign is_equ   = (key_code == KEY_EQU);
   assign is_clr   = (key_code == KEY_CLR);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad calculator sequencer: assembles two 2-digit operands and an operator,
// launches the calculation unit under a watchdog and captures its result.
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 12
) (
   input  logic        press_clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   input  logic        calc_done,
   input  logic [13:0] calc_result,
   input  logic        calc_err,
   output logic [7:0]  a1,
   output logic [7:0]  a0,
   output logic [7:0]  b1,
   output logic [7:0]  b0,
   output logic [7:0]  op,
   output logic        calc_start,
   output logic        calc_abort,
   output logic [13:0] result,
   output logic        result_valid,
   output logic        error,
   output logic        busy,
   output logic [2:0]  stage
);

   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_WARN  = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_SAT   = '1;

   logic is_digit, is_op, is_equ, is_clr;

   calc_key_classify u_classify (
      .key_code (key_code),
      .is_digit (is_digit),
      .is_op    (is_op),
      .is_equ   (is_equ),
      .is_clr   (is_clr)
   );

   wire key_dig = key_valid & is_digit;
   wire key_op  = key_valid & is_op;
   wire key_equ = key_valid & is_equ;
   wire key_clr = key_valid & is_clr;

   state_e            state_q, state_d;
   logic [7:0]        a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d, op_q, op_d;
   logic [13:0]       result_q, result_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              start_q, start_d, abort_q, abort_d;
   logic              rvalid_q, rvalid_d, error_q, error_d, busy_q, busy_d;
   logic [2:0]        stage_q, stage_d;

   always_comb begin
      // NOTE: every _d starts from its hold value so no branch can infer a latch.
      state_d  = state_q;
      a1_d     = a1_q;
      a0_d     = a0_q;
      b1_d     = b1_q;
      b0_d     = b0_q;
      op_d     = op_q;
      result_d = result_q;
      wd_d     = wd_q;
      start_d  = 1'b0;
      abort_d  = 1'b0;

      if (key_clr) begin
         state_d  = ST_IDLE;
         a1_d     = '0;
         a0_d     = '0;
         b1_d     = '0;
         b0_d     = '0;
         op_d     = '0;
         result_d = '0;
         abort_d  = (state_q == ST_CALC);
      end else begin
         unique case (state_q)
            ST_IDLE, ST_RESULT, ST_ERR: begin
               if (key_dig) begin
                  a1_d    = key_code;
                  a0_d    = '0;
                  state_d = ST_A1;
               end
            end
            ST_A1: begin
               if (key_dig) begin
                  a0_d    = key_code;
                  state_d = ST_A0;
               end else if (key_op) begin
                  a0_d    = a1_q;
                  a1_d    = '0;
                  op_d    = key_code;
                  state_d = ST_OP;
               end
            end
            ST_A0: begin
               if (key_op) begin
                  op_d    = key_code;
                  state_d = ST_OP;
               end
            end
            ST_OP: begin
               if (key_dig) begin
                  b1_d    = key_code;
                  b0_d    = '0;
                  state_d = ST_B1;
               end else if (key_op) begin
                  op_d = key_code;
               end
            end
            ST_B1: begin
               if (key_dig) begin
                  b0_d    = key_code;
                  state_d = ST_B0;
               end else if (key_equ) begin
                  b0_d    = b1_q;
                  b1_d    = '0;
                  state_d = ST_CALC;
                  start_d = 1'b1;
                  wd_d    = '0;
               end
            end
            ST_B0: begin
               if (key_equ) begin
                  state_d = ST_CALC;
                  start_d = 1'b1;
                  wd_d    = '0;
               end
            end
            ST_CALC: begin
               if (wd_q != WD_SAT) wd_d = wd_q + 1'b1;
               // A done in the launch cycle belongs to a stale operation.
               if (calc_done && !start_q) begin
                  if (calc_err) begin
                     state_d = ST_ERR;
                  end else begin
                     result_d = calc_result;
                     state_d  = ST_RESULT;
                  end
               end else if (wd_q >= WD_LIMIT) begin
                  state_d = ST_ERR;
               end else if (wd_q == WD_WARN) begin
                  abort_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      rvalid_d = (state_d == ST_RESULT);
      error_d  = (state_d == ST_ERR);
      busy_d   = (state_d == ST_CALC);
      stage_d  = stage_of(state_d);
   end

   // NOTE: non-blocking only here, so every flop samples pre-edge values.
   always_ff @(posedge press_clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a1_q     <= '0;
         a0_q     <= '0;
         b1_q     <= '0;
         b0_q     <= '0;
         op_q     <= '0;
         result_q <= '0;
         wd_q     <= '0;
         start_q  <= 1'b0;
         abort_q  <= 1'b0;
         rvalid_q <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
         stage_q  <= STG_IDLE;
      end else begin
         state_q  <= state_d;
         a1_q     <= a1_d;
         a0_q     <= a0_d;
         b1_q     <= b1_d;
         b0_q     <= b0_d;
         op_q     <= op_d;
         result_q <= result_d;
         wd_q     <= wd_d;
         start_q  <= start_d;
         abort_q  <= abort_d;
         rvalid_q <= rvalid_d;
         error_q  <= error_d;
         busy_q   <= busy_d;
         stage_q  <= stage_d;
      end
   end

   assign a1           = a1_q;
   assign a0           = a0_q;
   assign b1           = b1_q;
   assign b0           = b0_q;
   assign op           = op_q;
   assign result       = result_q;
   assign calc_start   = start_q;
   assign calc_abort   = abort_q;
   assign result_valid = rvalid_q;
   assign error        = error_q;
   assign busy         = busy_q;
   assign stage        = stage_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with hand-computed expectations.
module tb_calc_seq_ctrl;

   logic        press_clk;
   logic        rst;
   logic        key_valid;
   logic [7:0]  key_code;
   logic        calc_done;
   logic [13:0] calc_result;
   logic        calc_err;
   logic [7:0]  a1, a0, b1, b0, op;
   logic        calc_start, calc_abort;
   logic [13:0] result;
   logic        result_valid, error, busy;
   logic [2:0]  stage;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;
   int abort_cnt = 0;
   int start_mark, abort_mark;

   calc_seq_ctrl #(.TIMEOUT(12)) dut (
      .press_clk    (press_clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .calc_done    (calc_done),
      .calc_result  (calc_result),
      .calc_err     (calc_err),
      .a1           (a1),
      .a0           (a0),
      .b1           (b1),
      .b0           (b0),
      .op           (op),
      .calc_start   (calc_start),
      .calc_abort   (calc_abort),
      .result       (result),
      .result_valid (result_valid),
      .error        (error),
      .busy         (busy),
      .stage        (stage)
   );

   initial begin
      press_clk = 1'b0;
      forever #5 press_clk = ~press_clk;
   end

   always @(posedge press_clk) begin
      if (calc_start) start_cnt++;
      if (calc_abort) abort_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: run did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge press_clk);
      #1;
   endtask

   task automatic press(input logic [7:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick();
      key_valid = 1'b0;
      key_code  = 8'h00;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a1"}, a1, 0);
      check({tag, "_a0"}, a0, 0);
      check({tag, "_b1"}, b1, 0);
      check({tag, "_b0"}, b0, 0);
      check({tag, "_op"}, op, 0);
      check({tag, "_ctl"}, {calc_start, calc_abort, result_valid, error, busy}, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_stage"}, stage, 0);
   endtask

   initial begin
      rst         = 1'b1;
      key_valid   = 1'b0;
      key_code    = 8'h00;
      calc_done   = 1'b0;
      calc_result = '0;
      calc_err    = 1'b0;
      #12;
      check_all_zero("reset");
      rst = 1'b0;

      // Full 4-digit entry, done three cycles after start.
      start_mark = start_cnt;
      press(8'h01);
      check("t1_a1_stage", {a1, 5'(stage)}, {8'h01, 5'd1});
      press(8'h02);
      check("t1_a0_stage", {a0, 5'(stage)}, {8'h02, 5'd2});
      press(8'hF0);
      press(8'h03);
      press(8'h04);
      check("t1_b0_stage", stage, 4);
      press(8'hE0);
      check("t1_start_busy", {calc_start, busy}, 2'b11);
      tick();
      check("t1_start_once", calc_start, 0);
      tick();
      tick();
      calc_done   = 1'b1;
      calc_result = 14'd46;
      tick();
      calc_done   = 1'b0;
      check("t1_operands", {a1, a0, op, b1, b0}, {8'h01, 8'h02, 8'hF0, 8'h03, 8'h04});
      check("t1_result", result, 46);
      check("t1_flags", {result_valid, busy, error, stage}, {3'b100, 3'd5});
      check("t1_start_count", start_cnt - start_mark, 1);

      // Single-digit operands are right-justified; done in launch cycle ignored.
      press(8'h07);
      check("t2_a_entry", {a1, a0, stage}, {8'h07, 8'h00, 3'd1});
      press(8'hF2);
      check("t2_a_justify", {a1, a0, op, stage}, {8'h00, 8'h07, 8'hF2, 3'd3});
      press(8'h06);
      press(8'hE0);
      calc_done   = 1'b1;
      calc_result = 14'd99;
      tick();
      check("t2_done_at_start_ignored", {busy, result_valid, 14'(result)}, {2'b10, 14'd46});
      calc_result = 14'd42;
      tick();
      calc_done   = 1'b0;
      check("t2_b_justify", {b1, b0}, {8'h00, 8'h06});
      check("t2_result", {result_valid, 14'(result)}, {1'b1, 14'd42});

      // Calculation fault leaves result untouched; digit restarts entry.
      press(8'h09);
      press(8'h09);
      press(8'hF3);
      press(8'h00);
      press(8'h00);
      press(8'hE0);
      tick();
      calc_done   = 1'b1;
      calc_err    = 1'b1;
      calc_result = 14'd1234;
      tick();
      calc_done   = 1'b0;
      calc_err    = 1'b0;
      check("t3_error", {error, result_valid, busy, stage}, {3'b100, 3'd6});
      check("t3_result_held", result, 42);
      press(8'h05);
      check("t3_restart", {a1, error, stage}, {8'h05, 1'b0, 3'd1});

      // Watchdog: no done, abort at start+12, ERR on the next cycle.
      press(8'h03);
      press(8'hF0);
      press(8'h02);
      abort_mark = abort_cnt;
      press(8'hE0);
      for (int i = 0; i < 11; i++) tick();
      check("t4_no_early_abort", {calc_abort, busy, 32'(abort_cnt - abort_mark)}, {2'b01, 32'd0});
      tick();
      check("t4_abort_pulse", {calc_abort, busy, error}, 3'b110);
      tick();
      check("t4_err", {calc_abort, busy, error, stage}, {3'b001, 3'd6});
      check("t4_abort_count", abort_cnt - abort_mark, 1);
      check("t4_operands_held", {a1, a0, op, b1, b0}, {8'h05, 8'h03, 8'hF0, 8'h00, 8'h02});

      // Clear coincident with done: clear wins, abort pulsed, result zeroed.
      press(8'h01);
      press(8'hF1);
      press(8'h02);
      press(8'hE0);
      tick();
      key_valid   = 1'b1;
      key_code    = 8'hE1;
      calc_done   = 1'b1;
      calc_result = 14'd77;
      tick();
      key_valid   = 1'b0;
      key_code    = 8'h00;
      calc_done   = 1'b0;
      check("t5_clear_abort", calc_abort, 1);
      check("t5_clear_state", {result_valid, busy, error, stage}, {3'b000, 3'd0});
      check("t5_clear_regs", {a1, a0, op, b1, b0, 14'(result)}, '0);
      tick();
      check("t5_abort_one_cycle", calc_abort, 0);

      // Asynchronous reset in B1 and in CALC.
      press(8'h04);
      press(8'hF0);
      press(8'h06);
      check("t6_in_b1", {b1, stage}, {8'h06, 3'd3});
      #2 rst = 1'b1;
      #1 check_all_zero("t6_rst_b1");
      #2 rst = 1'b0;
      press(8'h08);
      press(8'hF1);
      press(8'h03);
      press(8'hE0);
      tick();
      tick();
      abort_mark = abort_cnt;
      #2 rst = 1'b1;
      #1 check_all_zero("t6_rst_calc");
      #2 rst = 1'b0;
      tick();
      check("t6_no_abort", abort_cnt - abort_mark, 0);
      press(8'h00);
      press(8'hF1);
      check("t6_after_rst", {a1, a0, op, stage}, {8'h00, 8'h00, 8'hF1, 3'd3});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller for the two-operand keypad calculator. It consumes decoded key strobes, assembles the operand digits and the operator, and launches the multi-cycle calculation unit through a start/done handshake. It guards that handshake with a watchdog, captures the result, and exports entry-progress and status for the display path. It sits between the keypad encoder and the calculation/BCD datapath, and replaces ad-hoc latching with a single synchronous FSM.

## Interface
- TIMEOUT, 12: cycles `calc_done` is awaited after `calc_start` before an error is forced (range 2–15).
- press_clk  in  1  controller clock; every input is synchronous to it.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  single-cycle strobe; `key_code` is valid this cycle.
- key_code  in  8  encoded key: digit 8'h00–8'h09; operator 8'hF0 add, F1 sub, F2 mul, F3 div; 8'hE0 equal; 8'hE1 clear.
- calc_done  in  1  calculation unit finished; `calc_result`/`calc_err` valid this cycle.
- calc_result  in  14  binary result (0–9999).
- calc_err  in  1  calculation fault (divide by zero, negative).
- a1, a0, b1, b0, op  out  8 each  registered operand digits and operator, held stable while busy.
- calc_start  out  1  one-cycle launch pulse.
- calc_abort  out  1  one-cycle cancel pulse.
- result  out  14  captured result.
- result_valid  out  1  high while in RESULT.
- error  out  1  high while in ERR.
- busy  out  1  high while in CALC.
- stage  out  3  entry progress: 0 idle, 1 A1, 2 A0, 3 op/B1, 4 B0, 5 result, 6 error.

## Operation
- States: IDLE, A1, A0, OP, B1, B0, CALC, RESULT, ERR. One-hot encoding.
- Clear key (any state) → IDLE. a1/a0/b1/b0/op/result zeroed. In CALC it also pulses `calc_abort`. Clear has priority over every other event.
- IDLE: a digit sets a1=key, a0=0 → A1. Other keys are ignored.
- A1: digit sets a0=key → A0. An operator right-justifies the operand (a0=a1, a1=0), stores op → OP.
- A0: operator stores op → OP. Digits (3rd digit) and equal are ignored.
- OP: digit sets b1=key, b0=0 → B1. A second operator replaces op. Equal is ignored.
- B1: digit sets b0=key → B0. Equal right-justifies (b0=b1, b1=0) → CALC.
- B0: equal → CALC. Digits and operators are ignored.
- CALC: all keys except clear are ignored.
  - `calc_done`=1, `calc_err`=0: result=calc_result → RESULT.
  - `calc_done`=1, `calc_err`=1: → ERR.
  - Watchdog reaches TIMEOUT: pulse `calc_abort` → ERR.
- RESULT: a digit starts a new entry (as from IDLE). Operators and equal are ignored.
- ERR: same as RESULT. `result` holds its last value.
- A 4-bit watchdog counter clears on entry to CALC and increments each CALC cycle. It saturates and is not used elsewhere.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog 0.
- Key accepted on the press_clk edge where `key_valid`=1. Register and state updates are visible the following cycle.
- `calc_start` is high for exactly the first cycle in CALC, i.e. one cycle after equal is accepted.
- `calc_done` is sampled only from the cycle after `calc_start`. A done coincident with `calc_start` is ignored.
- Done captured at edge n: `result_valid`=1 and `busy`=0 from cycle n+1.
- Timeout: with `calc_start` at cycle s and no done, ERR is entered at the edge ending cycle s+TIMEOUT. `calc_abort` is high in the cycle s+TIMEOUT.
- If `calc_done` and the timeout edge coincide, done wins.
- If `calc_done` and clear coincide, clear wins: abort is pulsed and the result is discarded.
- a1/a0/b1/b0/op are stable from `calc_start` until leaving CALC.
- `rst` mid-operation: immediate return to reset values, no `calc_abort` pulse. The datapath is reset by the same `rst`.

## Structure
- Shared package `calc_pkg`: key codes (KEY_EQU 8'hE0, KEY_CLR 8'hE1, OP_ADD..OP_DIV 8'hF0–F3), state one-hot constants, stage codes.
- Sub-module `calc_key_classify`: combinational decode of `key_code` into is_digit, is_op, is_equ, is_clr. It is reused by the display path.
- The watchdog counter stays inline.

## Test plan
- Keys 1,2,F0,3,4,E0; done with result 46 three cycles after start → a1=01, a0=02, op=F0, b1=03, b0=04; one `calc_start` pulse; result=46; `result_valid`=1; stage=5.
- Keys 7,F2,6,E0; done with 42 → a1=00, a0=07, b1=00, b0=06; result=42.
- Keys 9,9,F3,0,0,E0; done with `calc_err`=1 → `error`=1, stage=6, result unchanged. Then key 5 → A1 with a1=05.
- Complete entry with `calc_done` held low → `calc_abort` at cycle start+12, ERR entered next cycle, `busy` low.
- Clear asserted in the same cycle as `calc_done` during CALC → IDLE, `calc_abort` pulse, result=0.
- `rst` asserted in B1 and mid-CALC → all outputs 0 asynchronously, IDLE. Keys 0,F1 still order correctly afterwards.
